pc16: RTL and testbench

//   16-bit program counter for the Hack-style CPU. It consumes the ALU/A-register

---
 rtl/pc16_pkg.sv | 5 +
 rtl/register16.sv | 17 +
 rtl/pc16.sv | 47 ++++
 tb/tb_pc16.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc16_pkg.sv
// Shared constants for the Hack-style CPU datapath.
package pc16_pkg;
   localparam int          WORD_W   = 16;
   localparam logic [15:0] PC_RESET = 16'h0000;
endpackage

// File: rtl/register16.sv
// Plain word register: a bank of d flops on one shared clock, no reset.
// One cycle latency; it is always enabled, so hold is done upstream by recirculating q.
module register16
   import pc16_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      q <= d;
   end

endmodule

// File: rtl/pc16.sv
// Program counter: reset / load / increment / hold, in that priority order.
// One cycle latency, fully registered output; there is no stall input.
module pc16
   import pc16_pkg::*;
#(
   parameter int               WIDTH     = WORD_W,
   parameter logic [WIDTH-1:0] RESET_VAL = PC_RESET
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] hold_or_inc;
   logic [WIDTH-1:0] load_sel;
   logic [WIDTH-1:0] nxt;

   // Half-adder ripple with carry-in 1; the final carry is dropped, so the count wraps.
   always_comb begin
      logic c;
      c       = 1'b1;
      inc_val = '0;
      for (int i = 0; i < WIDTH; i++) begin
         inc_val[i] = out[i] ^ c;
         c          = out[i] & c;
      end
   end

   always_comb begin
      hold_or_inc = inc   ? inc_val  : out;
      load_sel    = load  ? in       : hold_or_inc;
      nxt         = rst_n ? load_sel : RESET_VAL;
   end

   register16 #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk (clk),
      .d   (nxt),
      .q   (out)
   );

endmodule

// File: tb/tb_pc16.sv
// Bench for pc16: directed scenarios plus a random run against a reference model.
module tb_pc16;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic        inc;
   logic [15:0] out;

   int checks = 0;
   int errors = 0;

   int mdl_val   = 0;
   bit mdl_valid = 0;

   pc16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .load  (load),
      .inc   (inc),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle, advance the model by one edge, then compare just after the edge.
   task automatic cycle(input logic r, input logic l, input logic i, input logic [15:0] v);
      rst_n = r;
      load  = l;
      inc   = i;
      in    = v;
      @(posedge clk);
      if (!r) begin
         mdl_val   = 0;
         mdl_valid = 1;
      end else if (l) begin
         mdl_val = int'(v);
      end else if (i) begin
         mdl_val = (mdl_val + 1) % 65536;
      end
      #1;
      if (mdl_valid) check("model", out, 16'(mdl_val));
   endtask

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      inc   = 1'b0;
      in    = 16'h0000;
      @(negedge clk);

      // Reset dominates load
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h1234);
         check("rst_hold", out, 16'h0000);
      end

      // Load then count
      cycle(1'b1, 1'b1, 1'b0, 16'h1234);
      check("load1234", out, 16'h1234);
      for (int k = 1; k <= 3; k++) begin
         cycle(1'b1, 1'b0, 1'b1, 16'($urandom));
         check("inc1234", out, 16'(16'h1234 + k));
      end

      // Wrap without flag
      cycle(1'b1, 1'b1, 1'b0, 16'hFFFE);
      check("wrap_ld", out, 16'hFFFE);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("wrap_ffff", out, 16'hFFFF);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("wrap_0000", out, 16'h0000);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("wrap_0001", out, 16'h0001);

      // Load beats increment, taking in unmodified
      cycle(1'b1, 1'b1, 1'b0, 16'h0010);
      check("pre_0010", out, 16'h0010);
      cycle(1'b1, 1'b1, 1'b1, 16'hABCD);
      check("ld_and_inc", out, 16'hABCD);
      cycle(1'b1, 1'b0, 1'b0, 16'h5555);
      check("hold_abcd", out, 16'hABCD);

      // Reset in the middle of counting
      cycle(1'b1, 1'b1, 1'b0, 16'h0004);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("cnt_0005", out, 16'h0005);
      cycle(1'b0, 1'b0, 1'b1, 16'h0000);
      check("mid_rst", out, 16'h0000);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("resume1", out, 16'h0001);
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      check("resume2", out, 16'h0002);

      // Garbage on in must not leak through while not loading
      cycle(1'b1, 1'b1, 1'b0, 16'h4321);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b0, 1'b0, (k % 2 == 0) ? 16'hxxxx : 16'($urandom));
         check("x_hold", out, 16'h4321);
         check("x_free", 16'($isunknown(out)), 16'h0000);
      end

      // Random run against the model
      for (int k = 0; k < 10000; k++) begin
         cycle(($urandom_range(15) != 0), ($urandom_range(7) == 0),
               ($urandom_range(3) != 0), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
